// File: rtl/spi_cmd_sender.sv
// Mode-0 SPI command sender: latches one {cmd, data} packet and shifts it out
// MSB first under a single csb-low window, followed by an enforced csb-high gap.
module spi_cmd_sender #(
  parameter int unsigned PACKET_WIDTH = 24,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned HALF_PERIOD  = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [7:0]            cmd_word,
  input  logic [DATA_WIDTH-1:0] data_word,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csb
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = $clog2(PACKET_WIDTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PACKET_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [PACKET_WIDTH-1:0] sr, sr_nxt;
  logic                    csb_nxt, sclk_nxt, mosi_nxt, done_nxt;

  assign ready = (state == ST_IDLE);

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      csb     <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      sr      <= sr_nxt;
      csb     <= csb_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state and next-output decode; sclk itself tracks the high/low phase.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    sr_nxt      = sr;
    csb_nxt     = csb;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    done_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        csb_nxt  = 1'b1;
        sclk_nxt = 1'b0;
        mosi_nxt = 1'b0;
        cnt_nxt  = '0;
        if (valid) begin
          sr_nxt      = PACKET_WIDTH'({cmd_word, data_word});
          mosi_nxt    = cmd_word[7];
          csb_nxt     = 1'b0;
          bit_cnt_nxt = '0;
          state_nxt   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          sclk_nxt  = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt != HALF_LAST) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
          if (sclk) begin
            // Falling edge: present the next bit a full half period before it is sampled.
            sclk_nxt = 1'b0;
            sr_nxt   = {sr[PACKET_WIDTH-2:0], 1'b0};
            mosi_nxt = sr[PACKET_WIDTH-2];
          end else if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            csb_nxt     = 1'b1;
            mosi_nxt    = 1'b0;
            state_nxt   = ST_GAP;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            sclk_nxt    = 1'b1;
          end
        end
      end

      ST_GAP: begin
        csb_nxt  = 1'b1;
        sclk_nxt = 1'b0;
        mosi_nxt = 1'b0;
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        csb_nxt   = 1'b1;
        sclk_nxt  = 1'b0;
        mosi_nxt  = 1'b0;
      end
    endcase
  end

endmodule
